// File: rtl/pipe_pkg.sv
// pipe_pkg: shared defaults, ctrl bit positions and lane slicing helper for pipe_stage_reg
package pipe_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int NCH_DEF = 3;
  localparam int CTRL_W_DEF = 8;
  localparam int CTRL_MEMWR = 0;
  localparam int CTRL_WREG = 1;
  localparam int CTRL_OPC_LSB = 2;
  localparam int LANE_W = DATA_W_DEF;
  function automatic int lane_lsb(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: two-entry main+skid buffer with registered ready (used when PIPE_SKID_EN is defined)
module pipe_skid_buf import pipe_pkg::*; #(
  parameter int DW = NCH_DEF * DATA_W_DEF,
  parameter int CW = CTRL_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          stall_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [CW-1:0] in_ctrl,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] out_ctrl,
  output logic [1:0]    occ
);
  logic main_valid, skid_valid, push, pop;
  logic [DW-1:0] main_data, skid_data;
  logic [CW-1:0] main_ctrl, skid_ctrl;
  assign in_ready = stall_n && !skid_valid;
  assign push = in_valid && in_ready;
  assign pop = main_valid && out_ready && stall_n;
  assign out_valid = main_valid;
  assign out_data = main_data;
  assign out_ctrl = main_ctrl;
  assign occ = {1'b0, main_valid} + {1'b0, skid_valid};
  // pop refills main from skid (or the incoming entry); push while full and not popping parks in skid
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      main_data <= '0;
      skid_data <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else if (pop) begin
      main_valid <= skid_valid || push;
      main_data <= skid_valid ? skid_data : in_data;
      main_ctrl <= skid_valid ? skid_ctrl : (push ? in_ctrl : '0);
      skid_valid <= 1'b0;
      skid_ctrl <= '0;
    end else if (push && main_valid) begin
      skid_valid <= 1'b1;
      skid_data <= in_data;
      skid_ctrl <= in_ctrl;
    end else if (push) begin
      main_valid <= 1'b1;
      main_data <= in_data;
      main_ctrl <= in_ctrl;
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with stall/flush; PIPE_SKID_EN selects a two-entry skid buffer
module pipe_stage_reg import pipe_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NCH = NCH_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH*DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0]     in_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [1:0]            occ
);
  logic [CTRL_W-1:0] head_ctrl;
  assign out_ctrl = out_valid ? head_ctrl : '0;
`ifdef PIPE_SKID_EN
  pipe_skid_buf #(.DW(NCH*DATA_W), .CW(CTRL_W)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .stall_n(stall_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(head_ctrl),
    .occ(occ)
  );
`else
  logic main_valid, push, pop;
  logic [NCH*DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  assign in_ready = stall_n && (!main_valid || out_ready);
  assign push = in_valid && in_ready;
  assign pop = main_valid && out_ready && stall_n;
  assign out_valid = main_valid;
  assign out_data = main_data;
  assign head_ctrl = main_ctrl;
  assign occ = {1'b0, main_valid};
  // single register: push loads (replacing a popped head), pop alone empties
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_ctrl <= '0;
      main_data <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_ctrl <= '0;
    end else if (push) begin
      main_valid <= 1'b1;
      main_data <= in_data;
      main_ctrl <= in_ctrl;
    end else if (pop) begin
      main_valid <= 1'b0;
      main_ctrl <= '0;
    end
  end
`endif
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 16, width of one data lane.
REQ-002 Parameter NCH, default 3, number of data lanes (e.g. rs, rt, imm).
REQ-003 Parameter CTRL_W, default 8, control bits that are cleared on flush (opcode, mem_write, WriteReg, ...).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 stall_n  in  1  active-low global freeze.
REQ-008 flush  in  1  kill all held entries (bubble insertion).
REQ-009 in_valid  in  1  upstream entry present.
REQ-010 in_ready  out  1  stage can accept an entry.
REQ-011 in_data  in  NCH*DATA_W  lane payload, lane k at bits [k*DATA_W +: DATA_W].
REQ-012 in_ctrl  in  CTRL_W  control payload.
REQ-013 out_valid  out  1  head entry valid.
REQ-014 out_ready  in  1  downstream accepts.
REQ-015 out_data  out  NCH*DATA_W  head lane payload.
REQ-016 out_ctrl  out  CTRL_W  head control; SHALL read 0 whenever out_valid=0.
REQ-017 occ  out  2  number of valid entries held (0..2).

Function
REQ-018 Push SHALL occur when in_valid && in_ready && stall_n; pop SHALL occur when out_valid && out_ready && stall_n.
REQ-019 Latency: an entry pushed in cycle N SHALL be visible on out_* in cycle N+1 when the stage was empty.
REQ-020 Order SHALL be strictly FIFO; no entry is dropped or duplicated except by rst/flush.
REQ-021 Simultaneous push and pop with one entry held SHALL replace the head and leave occ unchanged.
REQ-022 stall_n=0 SHALL freeze all state, force in_ready=0, and keep out_valid/out_data/out_ctrl stable; no pop is counted.
REQ-023 flush=1 SHALL clear every entry valid and every ctrl register to 0 on the next edge (occ=0); lane data registers MAY hold stale values.
REQ-024 Priority SHALL be rst > flush > stall_n=0 > push/pop; an in-flight push in a flush cycle is discarded.
REQ-025 occ SHALL equal the number of valid entries; it SHALL never exceed 2, or 1 without PIPE_SKID_EN.

Reset
REQ-026 On rst: out_valid=0, out_ctrl=0, occ=0, and all control and skid registers are 0.
REQ-027 In the cycle after rst deasserts, in_ready SHALL be 1 if stall_n=1.
REQ-028 Reset mid-transfer SHALL discard every entry with no partial output.

Configuration
REQ-029 Macro PIPE_SKID_EN is defined: a two-entry main+skid buffer SHALL be used.
- in_ready SHALL be a register output: in_ready = !skid_valid.
- A push while main is full and there is no pop SHALL write the skid register.
- A pop SHALL move skid to main in the same edge.
REQ-030 Macro PIPE_SKID_EN is undefined: a single register SHALL be used with combinational in_ready = !main_valid || out_ready (gated by stall_n).

Structure
REQ-031 Package pipe_pkg SHALL hold:
- default DATA_W, NCH and CTRL_W constants;
- ctrl bit-index constants CTRL_MEMWR=0, CTRL_WREG=1, CTRL_OPC_LSB=2;
- the lane-slice width helper constant.
REQ-032 The skid register pair SHALL be a sub-module pipe_skid_buf, instantiated only under PIPE_SKID_EN.

Verification
REQ-033 Reset, then push data 0x1234/0x5678/0x9ABC with ctrl 0x03 while out_ready=1 -> out_valid=1 next cycle with identical payload; occ=1.
REQ-034 With PIPE_SKID_EN and out_ready=0, push A=0x0001 then B=0x0002 -> occ=2 and in_ready=0; raise out_ready -> A then B emerge on consecutive cycles.
REQ-035 Hold stall_n=0 for 3 cycles with entry 0x00FF held and in_valid=1 -> outputs stable, in_ready=0, occ unchanged; release -> normal flow resumes with no loss.
REQ-036 Assert flush together with in_valid=1 while occ=2 -> next cycle occ=0, out_valid=0, out_ctrl=0x00, and the flushed push never appears.
REQ-037 Assert rst while stalled and full -> next cycle all outputs are at reset values and in_ready=1 after release.
REQ-038 Run a random valid/ready/stall stream of 1000 entries against a scoreboard -> in-order, lossless delivery in both macro builds.
